// File: rtl/stop_watch_param.sv
// stop_watch_param: MM:SS up/down stopwatch with field adjust,
// blink and a registered 4-digit multiplexed 7-segment driver.
module stop_watch_param #(
   parameter int CLK_DIV   = 100_000_000,
   parameter int ADJ_DIV   = 50_000_000,
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 25_000_000,
   parameter int MAX_MIN   = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   input  logic       dir,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       done,
   output logic [7:0] seg,
   output logic [3:0] ad
);

   localparam int W1 = $clog2(CLK_DIV + 1);
   localparam int WA = $clog2(ADJ_DIV + 1);
   localparam int WS = $clog2(SCAN_DIV + 1);
   localparam int WB = $clog2(BLINK_DIV + 1);

   localparam logic [W1-1:0] C1_MAX = W1'(CLK_DIV - 1);
   localparam logic [WA-1:0] CA_MAX = WA'(ADJ_DIV - 1);
   localparam logic [WS-1:0] CS_MAX = WS'(SCAN_DIV - 1);
   localparam logic [WB-1:0] CB_MAX = WB'(BLINK_DIV - 1);

   localparam logic [3:0] MM1 = 4'(MAX_MIN / 10);
   localparam logic [3:0] MM0 = 4'(MAX_MIN % 10);

   logic [W1-1:0] cnt1;
   logic [WA-1:0] cnta;
   logic [WS-1:0] cnts;
   logic [WB-1:0] cntb;
   logic          tick1;
   logic          tick_adj;
   logic          tick_scan;
   logic          tick_blink;

   logic          running;
   logic          phase;
   logic [1:0]    idx;

   logic [3:0]    m1_n;
   logic [3:0]    m0_n;
   logic [3:0]    s1_n;
   logic [3:0]    s0_n;
   logic          done_n;
   logic          step;
   logic          upd;
   logic          dn_tick;
   logic          zero_c;
   logic          zero_n;

   logic [3:0]    dig;
   logic          blink;
   logic [7:0]    seg_n;
   logic [3:0]    ad_n;

   function automatic logic [7:0] sec_inc(input logic [3:0] t,
                                          input logic [3:0] u);
      if (u != 4'd9) return {t, u + 4'd1};
      if (t != 4'd5) return {t + 4'd1, 4'd0};
      return 8'h00;
   endfunction

   function automatic logic [7:0] min_inc(input logic [3:0] t,
                                          input logic [3:0] u);
      if ({t, u} == {MM1, MM0}) return 8'h00;
      if (u != 4'd9) return {t, u + 4'd1};
      return {t + 4'd1, 4'd0};
   endfunction

   // active-low {g,f,e,d,c,b,a}; anything above 9 is blank
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   assign tick1      = !adj && (cnt1 == C1_MAX);
   assign tick_adj   = (cnta == CA_MAX);
   assign tick_scan  = (cnts == CS_MAX);
   assign tick_blink = (cntb == CB_MAX);

   // the 1 Hz prescaler is parked while adjusting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt1 <= '0;
         cnta <= '0;
         cnts <= '0;
         cntb <= '0;
      end else begin
         cnt1 <= (adj || tick1) ? '0 : cnt1 + 1'b1;
         cnta <= tick_adj ? '0 : cnta + 1'b1;
         cnts <= tick_scan ? '0 : cnts + 1'b1;
         cntb <= tick_blink ? '0 : cntb + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running <= 1'b1;
         phase   <= 1'b0;
         idx     <= 2'd0;
      end else begin
         if (pause) running <= !running;
         if (tick_blink) phase <= !phase;
         if (tick_scan) idx <= idx + 2'd1;
      end
   end

   // a pause landing on tick1 swallows that tick
   assign step   = tick1 && running && !pause;
   assign zero_c = ({m1, m0, s1, s0} == 16'h0000);

   always_comb begin
      m1_n    = m1;
      m0_n    = m0;
      s1_n    = s1;
      s0_n    = s0;
      upd     = 1'b0;
      dn_tick = 1'b0;
      if (adj) begin
         if (tick_adj) begin
            upd = 1'b1;
            if (sel) {s1_n, s0_n} = sec_inc(s1, s0);
            else     {m1_n, m0_n} = min_inc(m1, m0);
         end
      end else if (step) begin
         upd = 1'b1;
         if (!dir) begin
            {s1_n, s0_n} = sec_inc(s1, s0);
            if ({s1, s0} == 8'h59) {m1_n, m0_n} = min_inc(m1, m0);
         end else begin
            dn_tick = 1'b1;
            if (!zero_c) begin
               if (s0 != 4'd0) s0_n = s0 - 4'd1;
               else begin
                  s0_n = 4'd9;
                  if (s1 != 4'd0) s1_n = s1 - 4'd1;
                  else begin
                     s1_n = 4'd5;
                     if (m0 != 4'd0) m0_n = m0 - 4'd1;
                     else begin
                        m0_n = 4'd9;
                        m1_n = m1 - 4'd1;
                     end
                  end
               end
            end
         end
      end
      zero_n = ({m1_n, m0_n, s1_n, s0_n} == 16'h0000);
      done_n = done;
      if (dn_tick && zero_n)    done_n = 1'b1;
      else if (upd && !zero_n)  done_n = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m1   <= 4'd0;
         m0   <= 4'd0;
         s1   <= 4'd0;
         s0   <= 4'd0;
         done <= 1'b0;
      end else begin
         m1   <= m1_n;
         m0   <= m0_n;
         s1   <= s1_n;
         s0   <= s0_n;
         done <= done_n;
      end
   end

   always_comb begin
      dig = s0;
      unique case (idx)
         2'd0:    dig = s0;
         2'd1:    dig = s1;
         2'd2:    dig = m0;
         default: dig = m1;
      endcase
      blink = adj && phase && (sel ? !idx[1] : idx[1]);
      seg_n = blink ? 8'hFF : {idx != 2'd2, seg7(dig)};
      ad_n  = ~(4'b0001 << idx);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= 8'hC0;
         ad  <= 4'b1110;
      end else begin
         seg <= seg_n;
         ad  <= ad_n;
      end
   end

endmodule

// File: tb/tb_stop_watch_param.sv
// tb_stop_watch_param: directed + randomized stimulus with a
// seconds-based reference model feeding a per-cycle scoreboard.
module tb_stop_watch_param;

   localparam int CLK_DIV   = 4;
   localparam int ADJ_DIV   = 2;
   localparam int SCAN_DIV  = 2;
   localparam int BLINK_DIV = 3;
   localparam int MAX_MIN   = 59;
   localparam int SPAN      = (MAX_MIN + 1) * 60;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       pause = 1'b0;
   logic       adj   = 1'b0;
   logic       sel   = 1'b0;
   logic       dir   = 1'b0;
   logic [3:0] m1, m0, s1, s0;
   logic       done;
   logic [7:0] seg;
   logic [3:0] ad;

   stop_watch_param #(
      .CLK_DIV(CLK_DIV), .ADJ_DIV(ADJ_DIV), .SCAN_DIV(SCAN_DIV),
      .BLINK_DIV(BLINK_DIV), .MAX_MIN(MAX_MIN)
   ) dut (
      .clk(clk), .reset(reset), .pause(pause), .adj(adj),
      .sel(sel), .dir(dir), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
      .done(done), .seg(seg), .ad(ad)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] m1, m0, s1, s0;
      logic       done;
      logic [7:0] seg;
      logic [3:0] ad;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [7:0] font [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   logic [3:0] anode [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   int         c1, ca, cs, cb, idx, ph, run, dn, t;
   logic [7:0] mseg;
   logic [3:0] mad;

   function automatic void chk(string name, logic [15:0] got,
                               logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      c1 = 0; ca = 0; cs = 0; cb = 0;
      idx = 0; ph = 0; run = 1; dn = 0; t = 0;
      mseg = 8'hC0; mad = 4'b1110;
   endfunction

   function automatic int digit(int slot);
      case (slot)
         0:       return (t % 60) % 10;
         1:       return (t % 60) / 10;
         2:       return (t / 60) % 10;
         default: return (t / 60) / 10;
      endcase
   endfunction

   task automatic model_edge();
      exp_t e;
      int   tn;
      bit   t1, ta, ts, tk;
      if (reset) model_reset();
      else begin
         t1 = !adj && c1 == CLK_DIV - 1;
         ta = ca == ADJ_DIV - 1;
         ts = cs == SCAN_DIV - 1;
         tk = cb == BLINK_DIV - 1;
         mseg = font[digit(idx)];
         if (idx == 2) mseg[7] = 1'b0;
         if (adj && ph == 1 && (sel ? idx < 2 : idx >= 2)) mseg = 8'hFF;
         mad = anode[idx];
         tn = t;
         if (adj) begin
            if (ta) begin
               if (sel) tn = (t / 60) * 60 + (t % 60 + 1) % 60;
               else tn = ((t / 60 + 1) % (MAX_MIN + 1)) * 60 + t % 60;
            end
         end else if (t1 && run == 1 && !pause) begin
            if (dir) begin
               tn = (t == 0) ? 0 : t - 1;
               if (tn == 0) dn = 1;
            end else tn = (t + 1) % SPAN;
         end
         if (tn != 0) dn = 0;
         t = tn;
         if (pause) run = 1 - run;
         c1 = (adj || t1) ? 0 : c1 + 1;
         ca = ta ? 0 : ca + 1;
         cs = ts ? 0 : cs + 1;
         cb = tk ? 0 : cb + 1;
         if (ts) idx = (idx + 1) % 4;
         if (tk) ph = 1 - ph;
      end
      e.m1 = 4'((t / 60) / 10);
      e.m0 = 4'((t / 60) % 10);
      e.s1 = 4'((t % 60) / 10);
      e.s0 = 4'((t % 60) % 10);
      e.done = (dn == 1);
      e.seg = mseg;
      e.ad = mad;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         me = q.pop_front();
         chk("m1", {12'h0, m1}, {12'h0, me.m1});
         chk("m0", {12'h0, m0}, {12'h0, me.m0});
         chk("s1", {12'h0, s1}, {12'h0, me.s1});
         chk("s0", {12'h0, s0}, {12'h0, me.s0});
         chk("done", {15'h0, done}, {15'h0, me.done});
         chk("seg", {8'h0, seg}, {8'h0, me.seg});
         chk("ad", {12'h0, ad}, {12'h0, me.ad});
      end
   end

   task automatic cyc(input logic p, input logic a,
                      input logic s, input logic d);
      pause = p; adj = a; sel = s; dir = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_time(input int mins, input int secs);
      int g;
      g = 0;
      while (t / 60 != mins && g < 400) begin
         cyc(1'b0, 1'b1, 1'b0, dir);
         g++;
      end
      if (g >= 400) chk("set_min_timeout", 16'd1, 16'd0);
      g = 0;
      while (t % 60 != secs && g < 400) begin
         cyc(1'b0, 1'b1, 1'b1, dir);
         g++;
      end
      if (g >= 400) chk("set_sec_timeout", 16'd1, 16'd0);
   endtask

   task automatic chk_time(string name, int mm, int ss, bit dd);
      chk({name, "_min"}, {8'h0, m1, m0}, 16'((mm / 10) * 16 + mm % 10));
      chk({name, "_sec"}, {8'h0, s1, s0}, 16'((ss / 10) * 16 + ss % 10));
      chk({name, "_done"}, {15'h0, done}, {15'h0, dd});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ra, rs, rd, rp;
      int g;
      model_reset();
      @(negedge clk);
      chk("rst_ad", {12'h0, ad}, 16'h000E);
      chk("rst_seg", {8'h0, seg}, 16'h00C0);
      chk_time("rst", 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      repeat (40) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("up40", 0, 10, 1'b0);

      set_time(59, 58);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("wrap_a", 59, 59, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("wrap_b", 0, 0, 1'b0);

      set_time(0, 2);
      repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk_time("down", 0, 0, 1'b1);
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk_time("down_hold", 0, 0, 1'b1);

      set_time(0, 5);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk_time("pause_tick", 0, 5, 1'b0);
      repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("paused", 0, 5, 1'b0);
      g = 0;
      while (c1 != CLK_DIV - 1 && g < 8) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         g++;
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("resume_3", 0, 5, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_time("resume_4", 0, 6, 1'b0);

      set_time(0, 58);
      repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk_time("adj_sec", 0, 1, 1'b0);

      set_time(3, 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      g = 0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      while (ad != 4'b1011 && g < 16) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         g++;
      end
      chk("scan_m0_ad", {12'h0, ad}, 16'h000B);
      chk("scan_m0_seg", {8'h0, seg}, 16'h0030);

      #2 reset = 1'b1;
      #1;
      chk("async_ad", {12'h0, ad}, 16'h000E);
      chk("async_seg", {8'h0, seg}, 16'h00C0);
      chk_time("async", 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      ra = 0; rs = 0; rd = 0;
      repeat (4000) begin
         if ($urandom_range(0, 63) == 0) ra = !ra;
         if ($urandom_range(0, 31) == 0) rs = !rs;
         if ($urandom_range(0, 47) == 0) rd = !rd;
         rp = ($urandom_range(0, 23) == 0);
         reset = ($urandom_range(0, 699) == 0);
         cyc(rp, ra, rs, rd);
      end
      reset = 1'b0;

      repeat (2) @(negedge clk);
      chk("queue_drain", 16'(q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
